// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg
// Shared definitions for the RV32M multiply/divide controller: the M-extension
// operation codes, the controller state type and small op-decode helpers used
// by the controller, the multiplier and the divide core.
package mdu_ctrl_pkg;

  // M-extension operation codes carried on req_op
  localparam logic [3:0] ALU_MUL    = 4'h0;
  localparam logic [3:0] ALU_MULH   = 4'h1;
  localparam logic [3:0] ALU_MULHSU = 4'h2;
  localparam logic [3:0] ALU_MULHU  = 4'h3;
  localparam logic [3:0] ALU_DIV    = 4'h4;
  localparam logic [3:0] ALU_DIVU   = 4'h5;
  localparam logic [3:0] ALU_REM    = 4'h6;
  localparam logic [3:0] ALU_REMU   = 4'h7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_FAST,
    ST_DIV,
    ST_DONE
  } state_t;

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  function automatic logic is_signed_div(input logic [3:0] op);
    return (op == ALU_DIV) || (op == ALU_REM);
  endfunction

  function automatic logic is_rem_op(input logic [3:0] op);
    return (op == ALU_REM) || (op == ALU_REMU);
  endfunction

  // Divides whose result is fixed by the ISA and never need the iterative
  // core: divide-by-zero and the single signed overflow case.
  function automatic logic is_fast_div(input logic [3:0] op,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    return is_div_op(op) &&
           ((b == 32'h0) ||
            (is_signed_div(op) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// mdu_div_core
// 32-iteration restoring divider. On start it captures operand magnitudes and
// the result signs, then performs one shift-subtract step per cycle. done is
// high during the final step; result is valid in that same cycle with sign
// fix-up applied. abort synchronously drops any division in progress.
// Ports:
//   clk, rst_n       : clock, async active-low reset
//   start            : begin a division with a, b, signed_op, rem_op
//   abort            : cancel the current division (wins over start)
//   a, b             in 32 : dividend, divisor (b never 0 here)
//   signed_op        : DIV/REM semantics
//   rem_op           : return remainder instead of quotient
//   busy             out : a division is in progress
//   done             out : last iteration happening this cycle
//   result           out 32 : signed-corrected quotient or remainder
module mdu_div_core
  import mdu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_op,
  input  logic        rem_op,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  logic        running;
  logic [5:0]  count;
  logic [31:0] quo_q;
  logic [31:0] rem_q;
  logic [31:0] div_q;
  logic        neg_quo;
  logic        neg_rem;
  logic        rem_sel;

  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic        fits;
  logic [31:0] quo_next;
  logic [31:0] rem_next;

  assign a_mag = (signed_op && a[31]) ? (~a + 32'd1) : a;
  assign b_mag = (signed_op && b[31]) ? (~b + 32'd1) : b;

  // The partial remainder is always below the divisor, so the shifted value
  // never exceeds 2*div-1 and bit 32 of the difference is exactly the borrow.
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {1'b0, div_q};
  assign fits      = ~diff[32];
  assign quo_next  = {quo_q[30:0], fits};
  assign rem_next  = fits ? diff[31:0] : rem_shift[31:0];

  assign busy = running;
  assign done = running && (count == 6'd31);

  // The final step's outputs feed the fix-up directly so the controller can
  // capture the answer on the same edge the last iteration completes.
  assign result = rem_sel ? (neg_rem ? (~rem_next + 32'd1) : rem_next)
                          : (neg_quo ? (~quo_next + 32'd1) : quo_next);

  // Iteration registers: load on start, step while running, stop after count 31.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      count   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      rem_sel <= 1'b0;
    end else if (abort) begin
      running <= 1'b0;
      count   <= '0;
    end else if (start) begin
      running <= 1'b1;
      count   <= '0;
      quo_q   <= a_mag;
      rem_q   <= '0;
      div_q   <= b_mag;
      neg_quo <= signed_op & (a[31] ^ b[31]);
      neg_rem <= signed_op & a[31];
      rem_sel <= rem_op;
    end else if (running) begin
      quo_q <= quo_next;
      rem_q <= rem_next;
      if (done) begin
        running <= 1'b0;
        count   <= '0;
      end else begin
        count <= count + 6'd1;
      end
    end
  end

endmodule

// File: rtl/multiplier.sv
// multiplier
// Combinational RV32M multiplier. Produces the low word for MUL and the high
// word for MULH/MULHSU/MULHU; any other op code yields 0.
// Ports:
//   op     in  4  : operation code
//   a, b   in  32 : operands (rs1, rs2)
//   result out 32 : product word selected by op
module multiplier
  import mdu_ctrl_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic        a_signed;
  logic        b_signed;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] product;

  // Extending each operand to 64 bits with its own signedness makes a single
  // unsigned 64x64 multiply (mod 2^64) give the exact product for all variants.
  assign a_signed = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign b_signed = (op == ALU_MULH);
  assign a_ext    = {{32{a_signed & a[31]}}, a};
  assign b_ext    = {{32{b_signed & b[31]}}, b};
  assign product  = a_ext * b_ext;

  always_comb begin
    result = '0;
    case (op)
      ALU_MUL:                         result = product[31:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = product[63:32];
      default:                         result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl
// Sequencing controller for the RV32M multiply/divide unit. Accepts one
// operation at a time, runs it on the multiplier, the fixed-result fast path
// or the restoring divider, and returns a tagged result. flush aborts any
// operation in flight without producing a response.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   req_valid/req_ready        : request handshake
//   req_op  in 4               : M-extension op code
//   req_a, req_b in XLEN       : rs1, rs2
//   req_tag in TAG_W           : rd tag, echoed on rsp_tag
//   flush   in                 : kill the current operation
//   rsp_valid/rsp_ready        : response handshake
//   rsp_data out XLEN, rsp_tag out TAG_W : result and its tag
//   busy    out                : controller not idle
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [XLEN-1:0]  rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  state_t state;
  state_t next_state;

  logic [3:0]       op_q;
  logic [XLEN-1:0]  a_q;
  logic [XLEN-1:0]  b_q;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  result_q;

  logic             accept;
  logic             div_start;
  logic             div_busy;
  logic             div_done;
  logic [XLEN-1:0]  div_result;
  logic [XLEN-1:0]  mul_result;
  logic [XLEN-1:0]  fast_result;

  assign req_ready = (state == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign rsp_data  = result_q;
  assign rsp_tag   = tag_q;

  multiplier u_mul (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (mul_result)
  );

  mdu_div_core u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .a         (a_q),
    .b         (b_q),
    .signed_op (is_signed_div(op_q)),
    .rem_op    (is_rem_op(op_q)),
    .busy      (div_busy),
    .done      (div_done),
    .result    (div_result)
  );

  // Fast path only ever sees divide-by-zero or signed overflow.
  always_comb begin
    fast_result = '0;
    if (b_q == '0) begin
      fast_result = is_rem_op(op_q) ? a_q : '1;
    end else begin
      fast_result = is_rem_op(op_q) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= next_state;
  end

  // Next-state logic. flush is applied last so it overrides an accept and a
  // same-cycle DONE handshake alike. The divider is kicked in the first DIV
  // cycle, which doubles as its operand-setup cycle.
  always_comb begin
    next_state = state;
    div_start  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (!is_div_op(req_op))                       next_state = ST_MUL;
          else if (is_fast_div(req_op, req_a, req_b))   next_state = ST_FAST;
          else                                          next_state = ST_DIV;
        end
      end
      ST_MUL:  next_state = ST_DONE;
      ST_FAST: next_state = ST_DONE;
      ST_DIV: begin
        div_start = !div_busy && !flush;
        if (div_done) next_state = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (flush) next_state = ST_IDLE;
  end

  // Operand capture on accept and result capture from whichever path is
  // active; a flush leaves the result register untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= req_op;
        a_q   <= req_a;
        b_q   <= req_b;
        tag_q <= req_tag;
      end
      if (!flush) begin
        case (state)
          ST_MUL:  result_q <= mul_result;
          ST_FAST: result_q <= fast_result;
          ST_DIV:  if (div_done) result_q <= div_result;
          default: result_q <= result_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl
// Scoreboard bench for mdu_ctrl: requests push their hand-computed response
// (data, tag, first-valid latency) into a queue; a monitor pops and compares
// on every response handshake. Directed checks cover reset, backpressure,
// flush and asynchronous reset.
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [3:0]       req_op = '0;
  logic [31:0]      req_a = '0;
  logic [31:0]      req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             flush = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             busy;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    int               accept_cyc;
    int               lat;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_fail = 0;
  int   first_valid = 0;
  logic prev_valid = 1'b0;
  int   acc;
  int   exp_acc;

  mdu_ctrl #(.XLEN(32), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .flush     (flush),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: latency is measured to the edge at which rsp_valid is first seen.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (!prev_valid) first_valid = cyc + 1;
      if (rsp_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL unexpected_rsp: got data %h tag %h, expected no response", rsp_data, rsp_tag);
        end else begin
          e = sb.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("rsp_tag", 32'(rsp_tag), 32'(e.tag));
          check("rsp_latency", 32'(first_valid - e.accept_cyc), 32'(e.lat));
        end
      end
    end
    prev_valid = rst_n && rsp_valid;
  end

  // Offer a request, wait (bounded) for acceptance, log the expected response.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic [TAG_W-1:0] tag, input logic [31:0] exp_data,
                               input int lat, input bit track, output int acc_cyc);
    int   waited = 0;
    exp_t e;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(negedge clk);
    while (!req_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL accept_timeout: got req_ready 0 after %0d cycles, expected 1", waited);
      acc_cyc = -1;
    end else begin
      acc_cyc      = cyc + 1;
      e.data       = exp_data;
      e.tag        = tag;
      e.accept_cyc = acc_cyc;
      e.lat        = lat;
      if (track) sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || busy) && w < 200) begin
      @(posedge clk);
      w++;
    end
    if (sb.size() != 0 || busy) begin
      n_vec++;
      n_fail++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag_name, input logic v, input logic b,
                             input logic [31:0] d, input logic [TAG_W-1:0] t, input logic r);
    check({tag_name, "_rsp_valid"}, 32'(rsp_valid), 32'(v));
    check({tag_name, "_busy"},      32'(busy),      32'(b));
    check({tag_name, "_rsp_data"},  rsp_data,       d);
    check({tag_name, "_rsp_tag"},   32'(rsp_tag),   32'(t));
    check({tag_name, "_req_ready"}, 32'(req_ready), 32'(r));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("reset", 1'b0, 1'b0, 32'h0, '0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Multiply path
    applyStimulus(ALU_MULH,   32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, 2, 1'b1, acc);
    applyStimulus(ALU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 2, 1'b1, acc);
    applyStimulus(ALU_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd3, 32'hFFFF_FFFF, 2, 1'b1, acc);
    applyStimulus(ALU_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'h0000_0001, 2, 1'b1, acc);
    applyStimulus(4'hF,       32'h0000_0003, 32'h0000_0005, 5'd5, 32'h0000_0000, 2, 1'b1, acc);
    // Iterative divide path
    applyStimulus(ALU_DIV,  32'd100,       32'd7,         5'd6,  32'd14,        34, 1'b1, acc);
    applyStimulus(ALU_REM,  32'd100,       32'd7,         5'd7,  32'd2,         34, 1'b1, acc);
    applyStimulus(ALU_DIV,  32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFD, 34, 1'b1, acc);
    applyStimulus(ALU_REM,  32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFF, 34, 1'b1, acc);
    applyStimulus(ALU_DIV,  32'd7,         32'hFFFF_FFFE, 5'd10, 32'hFFFF_FFFD, 34, 1'b1, acc);
    applyStimulus(ALU_REM,  32'd7,         32'hFFFF_FFFE, 5'd11, 32'd1,         34, 1'b1, acc);
    applyStimulus(ALU_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd12, 32'hFFFF_FFFF, 34, 1'b1, acc);
    applyStimulus(ALU_REMU, 32'hFFFF_FFFF, 32'h10,        5'd13, 32'hF,         34, 1'b1, acc);
    applyStimulus(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'h0,         34, 1'b1, acc);
    // Fast path: divide-by-zero and signed overflow
    applyStimulus(ALU_DIVU, 32'h1234_5678, 32'h0,         5'd14, 32'hFFFF_FFFF, 2, 1'b1, acc);
    applyStimulus(ALU_REMU, 32'h1234_5678, 32'h0,         5'd15, 32'h1234_5678, 2, 1'b1, acc);
    applyStimulus(ALU_DIV,  32'd5,         32'h0,         5'd16, 32'hFFFF_FFFF, 2, 1'b1, acc);
    applyStimulus(ALU_REM,  32'd5,         32'h0,         5'd17, 32'd5,         2, 1'b1, acc);
    applyStimulus(ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 2, 1'b1, acc);
    applyStimulus(ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0,         2, 1'b1, acc);
    drain();

    // Backpressure: DONE held for 10 cycles, then handshake and immediate reissue
    rsp_ready = 1'b0;
    applyStimulus(ALU_MUL, 32'h1234_5678, 32'h10, 5'd21, 32'h2345_6780, 2, 1'b1, acc);
    for (int w = 0; w < 50 && !rsp_valid; w++) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data",  rsp_data,       32'h2345_6780);
      check("hold_rsp_tag",   32'(rsp_tag),   32'd21);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("post_hs_busy", 32'(busy), 32'd0);
    exp_acc = cyc + 1;
    applyStimulus(ALU_MULHU, 32'h10, 32'h1000_0000, 5'd22, 32'h1, 2, 1'b1, acc);
    check("b2b_accept_edge", 32'(acc), 32'(exp_acc));
    drain();

    // Flush at iteration 15 of a divide: no response, then a clean multiply
    applyStimulus(ALU_DIV, 32'd100, 32'd7, 5'd23, 32'd14, 34, 1'b0, acc);
    repeat (16) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (40) @(posedge clk);
    #1;
    applyStimulus(ALU_MUL, 32'd3, 32'd5, 5'd24, 32'd15, 2, 1'b1, acc);
    drain();

    // Asynchronous reset in the middle of a divide
    applyStimulus(ALU_DIV, 32'd100, 32'd7, 5'd25, 32'd14, 34, 1'b0, acc);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 1'b0, 1'b0, 32'h0, '0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(ALU_MULHU, 32'hFFFF_FFFF, 32'd2, 5'd26, 32'h1, 2, 1'b1, acc);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencing controller for the RV32M multiply/divide unit in the execute stage. It accepts one M-extension operation at a time over a valid/ready handshake and drives the combinational `multiplier` datapath through a registered issue/result path. It runs DIV/DIVU/REM/REMU on a 32-iteration restoring divider, handles divide-by-zero and signed overflow on a short fast path, and returns a tagged result on a second valid/ready handshake. Pipeline flush aborts any operation in flight.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `TAG_W`, 5: destination-register tag width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request accepted when `req_valid && req_ready`.
- `req_op` in 4: `ALU_MUL`/`MULH`/`MULHSU`/`MULHU`/`DIV`/`DIVU`/`REM`/`REMU` encoding.
- `req_a`, `req_b` in 32: rs1, rs2 operands.
- `req_tag` in TAG_W: rd tag, returned unchanged.
- `flush` in 1: kill the current operation.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes the result.
- `rsp_data` out 32: result.
- `rsp_tag` out TAG_W: tag of the result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, MUL, FAST, DIV, DONE.
- `req_ready = (state==IDLE) && !flush`.
- On accept, op, a, b and tag are latched into registers.
- Transitions out of IDLE on accept:
  - Multiply op → MUL.
  - Divide op with b==0, or signed DIV/REM with a==0x80000000 and b==0xFFFFFFFF → FAST.
  - Other divide ops → DIV.
  - Any other op code → MUL, giving result 0 (the multiplier default).
- MUL: the `multiplier` is fed from the latched operands and op. Its output is registered into the result register. Next state is DONE.
- FAST: the result register is loaded as follows, then next state is DONE.
  - Div-by-zero: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - Overflow: DIV → 0x80000000; REM → 0.
- DIV:
  - Signed ops take the magnitudes of a and b on entry.
  - Each cycle does one restoring shift-subtract step. A 6-bit counter runs 0..31.
  - After the step at count 31, sign fix-up is applied and next state is DONE.
  - Quotient sign is a_sign XOR b_sign. Remainder sign is a_sign.
  - DIV/REM select quotient or remainder.
- DONE: `rsp_valid`=1, and `rsp_data`/`rsp_tag` are held stable. On `rsp_ready`, next state is IDLE.
- `flush` in any state → IDLE on the next edge. No response is produced and the result register is not updated. Flush overrides both accept and a same-cycle DONE handshake, so the result is dropped.
- Reset: state IDLE, `rsp_valid`=0, `busy`=0, `rsp_data`=0, `rsp_tag`=0, counter 0. `req_ready` follows the combinational rule above, so it reads 1 in reset unless `flush` is high.

## Timing
- Accept at edge T.
- MUL and FAST paths: `rsp_valid` high from cycle T+2.
- DIV path: `rsp_valid` high from cycle T+34 (one setup cycle plus 32 iterations plus DONE).
- Back-to-back: a new request can be accepted one cycle after the DONE handshake, since IDLE is mandatory. Peak multiply throughput is one op per 3 cycles.
- Backpressure: DONE may be held indefinitely. Outputs stay stable while `rsp_valid && !rsp_ready`.
- No combinational path from `req_*` to `rsp_*`. `req_ready` depends only on state and `flush`.

## Structure
- Op encodings `ALU_MUL`..`ALU_REMU` go in the shared `defines.v`, with `ALU_DIV`/`DIVU`/`REM`/`REMU` added alongside the existing multiply codes. State encodings are local parameters.
- The existing `multiplier` block is instantiated unchanged.
- One new sub-module, `mdu_div_core`, holds the divide path: magnitude conversion, iteration registers, counter and sign fix-up. It has a `start`/`done` interface and a synchronous `abort` driven by `flush`.

## Test plan
- MULH a=0x80000000, b=0x80000000 accepted at T → `rsp_valid` at T+2, `rsp_data`=0x40000000, tag echoed. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 100/7 → 14 and REM 100/7 → 2, each with `rsp_valid` exactly at T+34. DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF.
- DIVU 0x12345678/0 → 0xFFFFFFFF at T+2; REMU 0x12345678/0 → 0x12345678. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0.
- Hold `rsp_ready`=0 for 10 cycles in DONE → `rsp_valid`, data and tag stable, `req_ready`=0. Then `rsp_ready`=1 → IDLE next cycle, and a new request is accepted the cycle after.
- Assert `flush` at iteration 15 of a DIV → IDLE next cycle, no `rsp_valid` ever. A following MUL 3×5 → 15 at T+2.
- Assert `rst_n` low mid-DIV → all outputs at reset values immediately, without waiting for a clock edge. Release → the idle handshake works.
